mdu_ctrl: RTL and testbench



---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_compute.sv | 53 +++++
 rtl/mdu_ctrl.sv | 113 +++++++++++
 tb/tb_mdu_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and widths for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // Ops 0..3 are the multi-cycle arithmetic ops; they all have bit 2 clear.
  function automatic logic is_arith(input logic [OP_W-1:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational 32x32 multiply / divide producing HI/LO results.
module mdu_compute
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi_res,
  output logic [DATA_W-1:0] lo_res,
  output logic              div_zero
);

  logic [63:0]               a_ext;
  logic [63:0]               b_ext;
  logic [63:0]               prod;
  logic [DATA_W-1:0]         b_safe;
  logic                      ovf;
  logic signed [DATA_W-1:0]  a_s;
  logic signed [DATA_W-1:0]  b_s;
  logic signed [DATA_W-1:0]  q_s;
  logic signed [DATA_W-1:0]  r_s;
  logic [DATA_W-1:0]         q_u;
  logic [DATA_W-1:0]         r_u;

  // Operand conditioning, product, quotient and remainder; op[0] selects unsigned.
  always_comb begin
    a_ext = op[0] ? {32'd0, a} : {{32{a[31]}}, a};
    b_ext = op[0] ? {32'd0, b} : {{32{b[31]}}, b};
    prod  = a_ext * b_ext;

    // A divisor of 1 makes divide-by-zero harmless and yields the
    // architected 0x80000000 / 0 result for the signed overflow case.
    div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);
    ovf      = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF) && (op == MD_DIV);
    b_safe   = ((b == 32'd0) || ovf) ? 32'd1 : b;

    a_s = $signed(a);
    b_s = $signed(b_safe);
    q_s = a_s / b_s;
    r_s = a_s % b_s;
    q_u = a / b_safe;
    r_u = a % b_safe;

    if (op[1]) begin
      hi_res = op[0] ? r_u : $unsigned(r_s);
      lo_res = op[0] ? q_u : $unsigned(q_s);
    end else begin
      hi_res = prod[63:32];
      lo_res = prod[31:0];
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO registers.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   md_op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              md_use_D,
  input  logic              hilo_sel,
  output logic              busy,
  output logic              stall_md,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] rd_data
);

  logic [0:0]        state;
  logic [0:0]        state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] hi_d;
  logic [DATA_W-1:0] lo_d;
  logic [DATA_W-1:0] hi_n;
  logic [DATA_W-1:0] lo_n;
  logic              dz_n;
  logic              load;
  logic [DATA_W-1:0] hi_res;
  logic [DATA_W-1:0] lo_res;
  logic              div_zero;

  mdu_compute u_compute (
    .op       (md_op),
    .a        (rs_data),
    .b        (rt_data),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state, counter and HI/LO update decisions.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hi_d    = hi;
    lo_d    = lo;
    load    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_arith(md_op)) begin
            load    = 1'b1;
            state_d = S_BUSY;
            cnt_d   = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end else if (md_op == MD_MTHI) begin
            hi_d = rs_data;
          end else if (md_op == MD_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (!dz_n) begin
            hi_d = hi_n;
            lo_d = lo_n;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: HI/LO, counter, pending-result shadow and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      hi_n <= '0;
      lo_n <= '0;
      dz_n <= 1'b0;
      busy <= 1'b0;
    end else begin
      hi   <= hi_d;
      lo   <= lo_d;
      cnt  <= cnt_d;
      busy <= (state_d == S_BUSY);
      if (load) begin
        hi_n <= hi_res;
        lo_n <= lo_res;
        dz_n <= div_zero;
      end
    end
  end

  assign stall_md = md_use_D & (busy | start);
  assign rd_data  = hilo_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table, scoreboard and corner sequences.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        md_use_D;
  logic        hilo_sel;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .md_use_D (md_use_D),
    .hilo_sel (hilo_sel),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        use_d;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    int          n;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t        vecs[17];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mdl_hi   = '0;
  logic [31:0] mdl_lo   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one op, follow its busy period, then compare against the scoreboard.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic use_d, input logic [31:0] e_hi, input logic [31:0] e_lo,
                        input int n);
    exp_t        e;
    int          cyc;
    logic [31:0] old_lo;
    sb.push_back('{hi: e_hi, lo: e_lo});
    old_lo = mdl_lo;
    @(posedge clk); #1;
    start = 1'b1; md_op = op; rs_data = rs; rt_data = rt; md_use_D = use_d; hilo_sel = 1'b0;
    @(negedge clk);
    chk("stall_issue", 32'(stall_md), 32'(use_d));
    chk("busy_issue", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      chk("stall_busy", 32'(stall_md), 32'(use_d));
      chk("rd_no_bypass", rd_data, old_lo);
      if (cyc > 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL busy_timeout: busy still high after %0d cycles, required %0d", cyc, n);
        break;
      end
    end
    chk("busy_len", 32'(cyc), 32'(n));
    e = sb.pop_front();
    chk("hi", hi, e.hi);
    chk("lo", lo, e.lo);
    chk("stall_idle", 32'(stall_md), 32'd0);
    hilo_sel = 1'b1; #1;
    chk("rd_hi", rd_data, e.hi);
    hilo_sel = 1'b0;
    mdl_hi = e.hi;
    mdl_lo = e.lo;
  endtask

  initial begin
    int cyc;

    vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{MD_DIVU,  32'd100,       32'd7,         1'b0, 32'd2,         32'd14,        10};
    vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 10};
    vecs[4]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[5]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'd0,         5};
    vecs[6]  = '{MD_MULT,  32'd7,         32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
    vecs[7]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 1'b0, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[8]  = '{MD_DIVU,  32'hFFFF_FFFF, 32'd2,         1'b1, 32'd1,         32'h7FFF_FFFF, 10};
    vecs[9]  = '{MD_MTHI,  32'h11,        32'd0,         1'b1, 32'h11,        32'h7FFF_FFFF, 0};
    vecs[10] = '{MD_MTLO,  32'h22,        32'd0,         1'b0, 32'h11,        32'h22,        0};
    vecs[11] = '{MD_DIV,   32'd5,         32'd0,         1'b1, 32'h11,        32'h22,        10};
    vecs[12] = '{MD_DIVU,  32'd5,         32'd0,         1'b0, 32'h11,        32'h22,        10};
    vecs[13] = '{3'd6,     32'd123,       32'd9,         1'b1, 32'h11,        32'h22,        0};
    vecs[14] = '{MD_DIVU,  32'h1234_5678, 32'h1000,      1'b1, 32'h678,       32'h12345,     10};
    vecs[15] = '{MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 32'd3,         10};
    vecs[16] = '{3'd7,     32'hDEAD,      32'hBEEF,      1'b1, 32'hFFFF_FFFF, 32'd3,         0};

    reset = 1'b1; start = 1'b0; md_op = '0; rs_data = '0; rt_data = '0;
    md_use_D = 1'b0; hilo_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    md_use_D = 1'b1; #1;
    chk("rst_stall", 32'(stall_md), 32'd0);

    for (int i = 0; i < 17; i++)
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].use_d,
             vecs[i].e_hi, vecs[i].e_lo, vecs[i].n);

    // Reset during the 3rd busy cycle of a MULTU discards the pending result.
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_MULTU; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF; md_use_D = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    chk("rstmid_late_busy", 32'(busy), 32'd0);
    chk("rstmid_late_hi", hi, 32'd0);
    chk("rstmid_late_lo", lo, 32'd0);
    mdl_hi = '0;
    mdl_lo = '0;

    // start pulsed while busy must be ignored; stall follows md_use_D & busy.
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_MULT; rs_data = 32'd3; rt_data = 32'd4; md_use_D = 1'b0;
    @(negedge clk);
    chk("ign_stall_issue", 32'(stall_md), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      md_use_D = 1'($urandom_range(0, 1));
      start    = (cyc == 2) || (cyc == 3);
      md_op    = MD_DIV;
      rs_data  = 32'd100;
      rt_data  = 32'd3;
      #1;
      chk("ign_stall", 32'(stall_md), 32'(md_use_D));
      if (cyc > 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL ign_timeout: busy still high after %0d cycles, required 5", cyc);
        break;
      end
    end
    start = 1'b0; md_use_D = 1'b0;
    chk("ign_len", 32'(cyc), 32'd5);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd12);
    repeat (3) @(negedge clk);
    chk("ign_after_busy", 32'(busy), 32'd0);
    chk("ign_after_lo", lo, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
